// File: rtl/calc_pkg.sv
// Shared definitions for the BCD arithmetic stage: opcodes, digit width,
// FSM state encoding and the nines-complement helper.
package calc_pkg;

    localparam int DIG_W = 4;
    localparam logic [DIG_W-1:0] DIG_MAX = 4'd9;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_NEG  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [DIG_W-1:0] nines(input logic [DIG_W-1:0] d);
        return DIG_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: two digits plus carry-in give a decimal digit and
// carry-out. Purely combinational; shared by the add and negate passes.
module bcd_digit_add
    import calc_pkg::*;
(
    input  logic [DIG_W-1:0] x,
    input  logic [DIG_W-1:0] y,
    input  logic             cin,
    output logic [DIG_W-1:0] s,
    output logic             cout
);

    logic [DIG_W:0] raw;
    logic [DIG_W:0] adj;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        raw  = {1'b0, x} + {1'b0, y} + {{DIG_W{1'b0}}, cin};
        adj  = raw - 5'd10;
        s    = raw[DIG_W-1:0];
        cout = 1'b0;
        if (raw > {1'b0, DIG_MAX}) begin
            s    = adj[DIG_W-1:0];
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_alu.sv
// Digit-serial 3-digit BCD add/subtract stage with start/busy/done handshake.
// Optional operand digit validation is enabled with the BCD_CHECK_EN macro.
module bcd_alu
    import calc_pkg::*;
#(
    parameter int NDIG = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [DIG_W-1:0] a1,
    input  logic [DIG_W-1:0] a10,
    input  logic [DIG_W-1:0] a100,
    input  logic [DIG_W-1:0] b1,
    input  logic [DIG_W-1:0] b10,
    input  logic [DIG_W-1:0] b100,
    output logic             busy,
    output logic             done,
    output logic [DIG_W-1:0] r1,
    output logic [DIG_W-1:0] r10,
    output logic [DIG_W-1:0] r100,
    output logic             neg,
    output logic             ovf,
    output logic             err
);

    localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t state_q, state_d;

    logic [KW-1:0]    k_q;
    logic             carry_q;
    logic             op_q;
    logic             neg_q;
    logic             ovf_q;
    logic [DIG_W-1:0] a_in [NDIG];
    logic [DIG_W-1:0] b_in [NDIG];
    logic [DIG_W-1:0] a_q  [NDIG];
    logic [DIG_W-1:0] b_q  [NDIG];
    logic [DIG_W-1:0] r_q  [NDIG];

    logic             last_digit;
    logic             bad_operand;
    logic [DIG_W-1:0] add_x;
    logic [DIG_W-1:0] add_y;
    logic [DIG_W-1:0] add_s;
    logic             add_cout;

    assign a_in[0] = a1;
    assign a_in[1] = a10;
    assign a_in[2] = a100;
    assign b_in[0] = b1;
    assign b_in[1] = b10;
    assign b_in[2] = b100;

    assign last_digit = (k_q == KW'(NDIG - 1));

`ifdef BCD_CHECK_EN
    logic err_q;
    assign bad_operand = (a1 > DIG_MAX) | (a10 > DIG_MAX) | (a100 > DIG_MAX)
                       | (b1 > DIG_MAX) | (b10 > DIG_MAX) | (b100 > DIG_MAX);
    assign err = err_q;
`else
    assign bad_operand = 1'b0;
    assign err         = 1'b0;
`endif

    // The one digit adder serves both passes: ADD feeds operand digits, NEG
    // feeds the nines complement of the stored result plus the carry chain.
    always_comb begin
        add_x = a_q[k_q];
        add_y = (op_q == OP_SUB) ? nines(b_q[k_q]) : b_q[k_q];
        if (state_q == ST_NEG) begin
            add_x = nines(r_q[k_q]);
            add_y = '0;
        end
    end

    bcd_digit_add u_digit_add (
        .x    (add_x),
        .y    (add_y),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_cout)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = bad_operand ? ST_DONE : ST_ADD;
            ST_ADD: begin
                if (last_digit) begin
                    // Subtract without a final carry means A < B: fix up the sign.
                    state_d = (op_q == OP_SUB && !add_cout) ? ST_NEG : ST_DONE;
                end
            end
            ST_NEG:  if (last_digit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the operand and result arrays are plain flop banks, not RAM, so
    // they are reset explicitly along with the rest of the datapath.
    always_ff @(posedge clock) begin
        if (reset) begin
            k_q     <= '0;
            carry_q <= 1'b0;
            op_q    <= OP_ADD;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                r_q[i] <= '0;
            end
`ifdef BCD_CHECK_EN
            err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        k_q     <= '0;
                        carry_q <= op;
                        op_q    <= op;
                        for (int i = 0; i < NDIG; i++) begin
                            a_q[i] <= a_in[i];
                            b_q[i] <= b_in[i];
                        end
`ifdef BCD_CHECK_EN
                        err_q <= bad_operand;
                        if (bad_operand) begin
                            neg_q <= 1'b0;
                            ovf_q <= 1'b0;
                            for (int i = 0; i < NDIG; i++) r_q[i] <= '0;
                        end
`endif
                    end
                end
                ST_ADD: begin
                    r_q[k_q] <= add_s;
                    carry_q  <= add_cout;
                    k_q      <= k_q + KW'(1);
                    if (last_digit) begin
                        k_q     <= '0;
                        carry_q <= 1'b1;
                        neg_q   <= 1'b0;
                        ovf_q   <= (op_q == OP_ADD) && add_cout;
                    end
                end
                ST_NEG: begin
                    r_q[k_q] <= add_s;
                    carry_q  <= add_cout;
                    k_q      <= k_q + KW'(1);
                    if (last_digit) begin
                        k_q   <= '0;
                        neg_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign r1   = r_q[0];
    assign r10  = r_q[1];
    assign r100 = r_q[2];
    assign neg  = neg_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/bcd_alu.md
Name: bcd_alu

Overview:
- Arithmetic stage directly downstream of the two 3-digit BCD operand registers (A and B).
- On a start strobe from the control FSM it computes A+B or A−B digit-serially, LSD first.
- It registers a 3-digit BCD result plus sign and overflow flags. The display mux shows these as a third source alongside A and B.
- Start/busy/done handshake; result held until the next accepted start.

Parameters:
- NDIG, 3, number of BCD digits per operand/result (digit-index counter sized for this; all tests at 3)

Ports:
- clock  input  1  system clock (same clock as control FSM and operand registers)
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request strobe; sampled only in IDLE
- op  input  1  0 = add, 1 = subtract (A−B); sampled with start
- a1, a10, a100  input  4 each  operand A BCD digits (ones, tens, hundreds)
- b1, b10, b100  input  4 each  operand B BCD digits
- busy  output  1  high from the cycle after start acceptance until done cycle inclusive
- done  output  1  one-cycle strobe; results valid from this cycle
- r1, r10, r100  output  4 each  result magnitude BCD digits
- neg  output  1  result negative (subtract only)
- ovf  output  1  add result ≥ 1000 (carry out of hundreds); r digits hold result mod 1000
- err  output  1  invalid-digit flag (see Optional Feature)

Behaviour:
- Reset (sync, active-high, takes priority at any time including mid-operation): state IDLE; busy=0, done=0, r1=r10=r100=0, neg=0, ovf=0, err=0; digit counter 0; latched operands 0.
- States: IDLE, ADD, NEG, DONE.
- IDLE: if start=1, latch A, B and op; state→ADD, counter=0, carry_in = op (1 for subtract). Outputs keep previous result.
- ADD, one digit per cycle at index k:
  - Operand digit b' = b_k (add) or 9−b_k (subtract, nines complement).
  - s = a_k + b' + carry; if s > 9 then digit = s−10, carry=1; else digit = s, carry=0.
  - Digit written into result register k.
  - After k=NDIG−1:
    - add: ovf=final carry, neg=0, →DONE
    - subtract, final carry=1: A≥B, result correct, neg=0, ovf=0, →DONE
    - subtract, final carry=0: A<B, →NEG with counter=0, carry_in=1
- NEG: tens-complements the result in place, one digit per cycle: digit = (9−r_k) + carry with the same decimal-carry rule. After the last digit: neg=1, →DONE.
- DONE: done=1 for exactly one cycle, busy=1, →IDLE.
- Latency, with start in cycle n: ADD occupies n+1..n+3. Add and non-negative subtract: done in n+4. Negative subtract: NEG in n+4..n+6, done in n+7.
- start while not IDLE is ignored; no queueing.
- Operand inputs may change after acceptance without effect.
- A−B with A=B: result 000, neg=0 (never −0).
- r digits change during ADD/NEG and are valid only from the done cycle; the consumer must latch or display only after done.

Optional Feature:
- Macro BCD_CHECK_EN.
- Defined: in IDLE on start, if any of the six operand digits > 9, skip ADD and go straight to DONE (done in n+1). err=1, r digits=0, neg=0, ovf=0. err clears on the next accepted start or on reset.
- Undefined: no check; err tied 0. Invalid digits produce unspecified but deterministic results through the normal path.

Decomposition:
- Shared package calc_pkg:
  - OP_ADD=1'b0, OP_SUB=1'b1
  - BCD digit width constant (4)
  - state encoding for IDLE/ADD/NEG/DONE
- One natural sub-module, bcd_digit_add: combinational, two 4-bit digits + carry-in → 4-bit digit + carry-out. Used by both ADD and NEG passes; instantiated once and shared by muxing its inputs.

Test Plan:
- A=123, B=456, op=add, start → done exactly 4 cycles after start; r=579, neg=0, ovf=0, busy high cycles n+1..n+4.
- A=999, B=001, add → r=000, ovf=1, done at n+4.
- A=500, B=123, sub → r=377, neg=0, done at n+4. A=B=250, sub → r=000, neg=0.
- A=123, B=500, sub → r=377, neg=1, done at n+7; second start pulsed at n+2 is ignored (single done, same result).
- Reset asserted at n+2 of an add → next cycle IDLE, busy=0, r=000, no done. A new 045+055 then yields r=100 at done.
- With BCD_CHECK_EN: A digit 0xA, add → done at n+1, err=1, r=000; a following valid 001+001 gives r=002, err=0.
